// File: rtl/uart_cmd_rx.sv
// UART receiver for the BLE command link: 8N1, LSB first, rdy/clr_rdy handshake with error pulses.
// Define UART_CMD_RX_PARITY_EN for 8E1 framing, which adds the par_err pulse output.
module uart_cmd_rx #(
  parameter int BAUD_DIV = 5208,
  parameter int CNT_W    = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
`ifdef UART_CMD_RX_PARITY_EN
  output logic       par_err,
`endif
  output logic       ovr_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF   = CNT_W'(BAUD_DIV / 2 - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             rx_p0, rx_p1, rx_p2;
  logic             tick, start_edge, good, ferr;
`ifdef UART_CMD_RX_PARITY_EN
  logic             par_bit, par_bit_nxt, perr;

  function automatic logic even_ok(input logic [7:0] d, input logic p);
    return ~^{d, p};
  endfunction
`endif

  // rx_p1 is the synchronized line; rx_p2 is its previous value for falling-edge detection
  assign tick       = (cnt == '0);
  assign start_edge = rx_p2 & ~rx_p1;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = tick ? RELOAD : cnt - 1'b1;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    good        = 1'b0;
    ferr        = 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
    par_bit_nxt = par_bit;
    perr        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = START;
          cnt_nxt   = HALF;
        end
      end
      START: begin
        if (tick) begin
          if (rx_p1) state_nxt = IDLE;
          else begin
            state_nxt   = DATA;
            bit_cnt_nxt = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nxt   = {rx_p1, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_CMD_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bit_nxt = rx_p1;
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught in IDLE
        if (tick) begin
          state_nxt = IDLE;
`ifdef UART_CMD_RX_PARITY_EN
          if (!rx_p1) ferr = 1'b1;
          else if (even_ok(shreg, par_bit)) good = 1'b1;
          else perr = 1'b1;
`else
          if (rx_p1) good = 1'b1;
          else ferr = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= 3'd0;
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_p2   <= 1'b1;
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      rx_p0   <= RX;
      rx_p1   <= rx_p0;
      rx_p2   <= rx_p1;
      frm_err <= ferr;
      // A completing byte wins over clr_rdy, and that case is not an overrun
      ovr_err <= good & rdy & ~clr_rdy;
`ifdef UART_CMD_RX_PARITY_EN
      par_err <= perr;
`endif
      if (good) begin
        rx_data <= shreg;
        rdy     <= 1'b1;
      end else if (clr_rdy) begin
        rdy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
`ifdef UART_CMD_RX_PARITY_EN
    par_bit <= par_bit_nxt;
`endif
  end

endmodule
